adc_scan_ctrl: RTL and testbench

Round-robin serial controller for the ADC128S022 8-channel, 12-bit ADC on the robot's line-sensor and analog board. It runs entirely in the 3.125 MHz domain produced by the frequency-scaling stage. It generates chip-select, serial clock and address stream, captures returned samples, and presents each one as a single-cycle valid pulse to downstream sensor logic.

---
 rtl/adc_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan controller for an ADC128S022: drives CS/SCK/DIN, captures 16-bit frames, emits one sample per frame.
// Optional leading-zero check is built only when ADC_ZERO_CHECK_EN is defined; otherwise frame_err is tied low.
module adc_scan_ctrl #(
    parameter int NUM_CH     = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk_3125KHz,
    input  logic        reset,
    input  logic        enable,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sck,
    output logic        adc_din,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    output logic        frame_err
);
    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    localparam logic [4:0] LAST_FRAME = 5'd31;
    localparam logic [4:0] LAST_GAP   = 5'(GAP_CYCLES - 1);
    localparam logic [2:0] LAST_CH    = 3'(NUM_CH - 1);
`ifdef ADC_ZERO_CHECK_EN
    localparam int SHIFT_W = 15;
`else
    localparam int SHIFT_W = 11;
`endif

    state_t              r_state, w_next_state;
    logic [4:0]          r_cnt, w_next_cnt;
    logic [2:0]          r_addr, r_prev_addr;
    logic                r_dummy;
    logic [SHIFT_W-1:0]  r_shift;
    logic                r_cs_n, r_sck, r_din;
    logic [11:0]         r_sample_data;
    logic [2:0]          r_sample_ch;
    logic                r_sample_valid;
    logic                w_frame_end;
    logic                w_din_next;

    assign w_frame_end = (r_state == FRAME) && (r_cnt == LAST_FRAME);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + 5'd1;
        case (r_state)
            IDLE: begin
                w_next_cnt = '0;
                if (enable) w_next_state = FRAME;
            end
            FRAME: begin
                if (r_cnt == LAST_FRAME) begin
                    w_next_state = GAP;
                    w_next_cnt   = '0;
                end
            end
            GAP: begin
                if (r_cnt == LAST_GAP) begin
                    w_next_state = enable ? FRAME : IDLE;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Bit b spans frame cycles 2b+1..2b+2; address bits occupy b = 2,3,4.
    always_comb begin
        w_din_next = 1'b0;
        if (w_next_state == FRAME) begin
            case (w_next_cnt)
                5'd5, 5'd6:  w_din_next = r_addr[2];
                5'd7, 5'd8:  w_din_next = r_addr[1];
                5'd9, 5'd10: w_din_next = r_addr[0];
                default:     w_din_next = 1'b0;
            endcase
        end
    end

    // Pin outputs are registered from the next-state decode so they never glitch.
    always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_addr         <= '0;
            r_prev_addr    <= '0;
            r_dummy        <= 1'b1;
            r_cs_n         <= 1'b1;
            r_sck          <= 1'b1;
            r_din          <= 1'b0;
            r_sample_data  <= '0;
            r_sample_ch    <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_cnt          <= w_next_cnt;
            r_cs_n         <= (w_next_state != FRAME);
            r_sck          <= (w_next_state != FRAME) || !w_next_cnt[0];
            r_din          <= w_din_next;
            r_sample_valid <= w_frame_end && !r_dummy;
            if (r_state == IDLE) begin
                r_addr  <= '0;
                r_dummy <= 1'b1;
            end else if (w_frame_end) begin
                r_addr      <= (r_addr == LAST_CH) ? 3'd0 : r_addr + 3'd1;
                r_prev_addr <= r_addr;
                r_dummy     <= 1'b0;
                if (!r_dummy) begin
                    r_sample_data <= {r_shift[10:0], adc_dout};
                    r_sample_ch   <= r_prev_addr;
                end
            end
        end
    end

    // Sampling on the sck rising edge: the clk edge that ends each odd frame cycle.
    always_ff @(posedge clk_3125KHz) begin
        if (r_state == FRAME && r_cnt[0])
            r_shift <= {r_shift[SHIFT_W-2:0], adc_dout};
    end

`ifdef ADC_ZERO_CHECK_EN
    logic r_frame_err;

    always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset)
            r_frame_err <= 1'b0;
        else
            r_frame_err <= w_frame_end && !r_dummy && (|r_shift[14:11]);
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    assign adc_cs_n     = r_cs_n;
    assign adc_sck      = r_sck;
    assign adc_din      = r_din;
    assign sample_data  = r_sample_data;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: a behavioural ADC128S022 slave plus a frame/sample logger,
// with per-scenario tasks comparing against expectations derived from the scan rules.
module tb_adc_scan_ctrl;
    localparam int NUM_CH     = 3;
    localparam int GAP_CYCLES = 2;
    localparam int PERIOD     = 32 + GAP_CYCLES;
`ifdef ADC_ZERO_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        dout = 1'b0;
    logic        cs_n, sck, din;
    logic [11:0] s_data;
    logic [2:0]  s_ch;
    logic        s_valid, s_err;

    int errors = 0;
    int checks = 0;

    adc_scan_ctrl #(.NUM_CH(NUM_CH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk_3125KHz (clk),
        .reset       (rst),
        .enable      (en),
        .adc_dout    (dout),
        .adc_cs_n    (cs_n),
        .adc_sck     (sck),
        .adc_din     (din),
        .sample_data (s_data),
        .sample_ch   (s_ch),
        .sample_valid(s_valid),
        .frame_err   (s_err)
    );

    always #5 clk = ~clk;

    // ADC slave model and observation log
    logic [11:0] chan_val [8];
    bit          err_inject = 1'b0;
    logic [2:0]  adc_addr   = 3'd0;
    logic [15:0] tx_word    = 16'h0;
    logic [15:0] din_bits   = 16'h0;
    logic        prev_cs    = 1'b1;
    logic        prev_sck   = 1'b1;
    int          cyc = 0, lo_len = 0, falls = 0, frames_done = 0;
    int          sck_viol = 0, err_unqual = 0;
    int          fr_len_q[$], fr_falls_q[$], fr_addr_q[$];
    int          v_ch_q[$], v_data_q[$], v_err_q[$], v_cyc_q[$], v_frame_q[$];

    always @(negedge clk) begin
        cyc++;
        if (cs_n === 1'b1 && sck === 1'b0) sck_viol++;
        if (s_err === 1'b1 && s_valid !== 1'b1) err_unqual++;
        if (cs_n === 1'b0) begin
            if (prev_cs) begin
                lo_len   = 0;
                falls    = 0;
                din_bits = 16'h0;
                tx_word  = {(err_inject ? 4'b0100 : 4'b0000), chan_val[adc_addr]};
            end
            lo_len++;
            if (prev_sck && sck === 1'b0) begin
                if (falls < 16) dout = tx_word[15 - falls];
                falls++;
            end
            if (!prev_sck && sck === 1'b1 && falls >= 1 && falls <= 16)
                din_bits[16 - falls] = din;
        end else if (!prev_cs) begin
            frames_done++;
            adc_addr = {din_bits[13], din_bits[12], din_bits[11]};
            fr_len_q.push_back(lo_len);
            fr_falls_q.push_back(falls);
            fr_addr_q.push_back(int'(adc_addr));
            dout = 1'b0;
        end
        if (s_valid === 1'b1) begin
            v_ch_q.push_back(int'(s_ch));
            v_data_q.push_back(int'(s_data));
            v_err_q.push_back(int'(s_err));
            v_cyc_q.push_back(cyc);
            v_frame_q.push_back(frames_done);
        end
        prev_cs  = cs_n;
        prev_sck = sck;
    end

    task automatic clear_logs();
        fr_len_q.delete(); fr_falls_q.delete(); fr_addr_q.delete();
        v_ch_q.delete(); v_data_q.delete(); v_err_q.delete(); v_cyc_q.delete(); v_frame_q.delete();
        sck_viol   = 0;
        err_unqual = 0;
    endtask

    task automatic wait_valids(input int n, input int budget, input string tag);
        int c = 0;
        while (v_ch_q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        checks++;
        if (v_ch_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d valid pulses, required %0d", tag, v_ch_q.size(), n);
        end
    endtask

    task automatic wait_frame_start(input int budget, input string tag);
        bit seen_hi = 1'b0;
        bit found   = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            if (cs_n === 1'b1) seen_hi = 1'b1;
            else if (seen_hi) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_frame_start: no frame start within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cs_n !== 1'b1)     begin errors++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
        checks++; if (sck !== 1'b1)      begin errors++; $display("FAIL rst_sck: got %b want 1", sck); end
        checks++; if (din !== 1'b0)      begin errors++; $display("FAIL rst_din: got %b want 0", din); end
        checks++; if (s_data !== 12'h0)  begin errors++; $display("FAIL rst_data: got %h want 000", s_data); end
        checks++; if (s_ch !== 3'd0)     begin errors++; $display("FAIL rst_ch: got %0d want 0", s_ch); end
        checks++; if (s_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b want 0", s_valid); end
        checks++; if (s_err !== 1'b0)    begin errors++; $display("FAIL rst_err: got %b want 0", s_err); end
    endtask

    task automatic test_scan(input bit rand_vals);
        int f0;
        rst = 1'b1;
        en  = 1'b0;
        err_inject = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++)
            chan_val[i] = rand_vals ? 12'($urandom_range(0, 4095)) : 12'hA5C;
        @(posedge clk);
        #1;
        clear_logs();
        f0 = frames_done;
        en = 1'b1;
        wait_valids(5, 8 * PERIOD, "scan");
        for (int k = 0; k < 5 && k < v_ch_q.size(); k++) begin
            checks++;
            if (v_ch_q[k] != k % NUM_CH) begin
                errors++; $display("FAIL scan_ch[%0d]: got %0d want %0d", k, v_ch_q[k], k % NUM_CH);
            end
            checks++;
            if (v_data_q[k] != int'(chan_val[k % NUM_CH])) begin
                errors++; $display("FAIL scan_data[%0d]: got %h want %h", k, v_data_q[k], chan_val[k % NUM_CH]);
            end
            checks++;
            if (v_frame_q[k] != f0 + 2 + k) begin
                errors++; $display("FAIL scan_frame_idx[%0d]: got %0d want %0d", k, v_frame_q[k] - f0, 2 + k);
            end
            checks++;
            if (v_err_q[k] != 0) begin
                errors++; $display("FAIL scan_err[%0d]: got %0d want 0", k, v_err_q[k]);
            end
            if (k > 0) begin
                checks++;
                if (v_cyc_q[k] - v_cyc_q[k-1] != PERIOD) begin
                    errors++; $display("FAIL scan_spacing[%0d]: got %0d want %0d", k, v_cyc_q[k] - v_cyc_q[k-1], PERIOD);
                end
            end
        end
        for (int j = 0; j < 6 && j < fr_addr_q.size(); j++) begin
            checks++;
            if (fr_addr_q[j] != j % NUM_CH) begin
                errors++; $display("FAIL scan_addr[%0d]: got %0d want %0d", j, fr_addr_q[j], j % NUM_CH);
            end
            checks++;
            if (fr_len_q[j] != 32) begin
                errors++; $display("FAIL scan_cs_len[%0d]: got %0d want 32", j, fr_len_q[j]);
            end
            checks++;
            if (fr_falls_q[j] != 16) begin
                errors++; $display("FAIL scan_sck_falls[%0d]: got %0d want 16", j, fr_falls_q[j]);
            end
        end
        checks++;
        if (sck_viol != 0) begin
            errors++; $display("FAIL scan_sck_idle: sck low with cs_n high %0d times, want 0", sck_viol);
        end
    endtask

    task automatic test_enable_drop();
        int nv, fd, f1;
        wait_frame_start(2 * PERIOD, "drop");
        repeat (10) @(posedge clk);
        #1 en = 1'b0;
        nv = v_ch_q.size();
        fd = frames_done;
        repeat (3 * PERIOD) @(posedge clk);
        #1;
        checks++;
        if (v_ch_q.size() != nv + 1) begin
            errors++; $display("FAIL drop_final_sample: got %0d pulses want %0d", v_ch_q.size() - nv, 1);
        end
        checks++;
        if (frames_done != fd + 1) begin
            errors++; $display("FAIL drop_frames: got %0d frames want 1", frames_done - fd);
        end
        if (v_ch_q.size() > nv) begin
            checks++;
            if (v_data_q[nv] != int'(chan_val[v_ch_q[nv]])) begin
                errors++; $display("FAIL drop_data: got %h want %h", v_data_q[nv], chan_val[v_ch_q[nv]]);
            end
        end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL drop_idle_cs_n: got %b want 1", cs_n); end
        checks++; if (sck !== 1'b1)  begin errors++; $display("FAIL drop_idle_sck: got %b want 1", sck); end
        f1 = frames_done;
        nv = v_ch_q.size();
        en = 1'b1;
        wait_valids(nv + 2, 5 * PERIOD, "reenable");
        if (v_ch_q.size() >= nv + 2) begin
            checks++;
            if (v_frame_q[nv] != f1 + 2) begin
                errors++; $display("FAIL reenable_dummy: first sample after frame %0d want 2", v_frame_q[nv] - f1);
            end
            checks++;
            if (v_ch_q[nv] != 0) begin
                errors++; $display("FAIL reenable_ch0: got %0d want 0", v_ch_q[nv]);
            end
            checks++;
            if (v_ch_q[nv+1] != 1 % NUM_CH) begin
                errors++; $display("FAIL reenable_ch1: got %0d want %0d", v_ch_q[nv+1], 1 % NUM_CH);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int f;
        wait_frame_start(2 * PERIOD, "midrst");
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (cs_n !== 1'b1)    begin errors++; $display("FAIL midrst_cs_n: got %b want 1", cs_n); end
        checks++; if (sck !== 1'b1)     begin errors++; $display("FAIL midrst_sck: got %b want 1", sck); end
        checks++; if (s_data !== 12'h0) begin errors++; $display("FAIL midrst_data: got %h want 000", s_data); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", s_valid); end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        f = frames_done;
        wait_valids(2, 5 * PERIOD, "midrst");
        if (v_ch_q.size() >= 2) begin
            checks++;
            if (v_frame_q[0] != f + 2) begin
                errors++; $display("FAIL midrst_dummy: first sample after frame %0d want 2", v_frame_q[0] - f);
            end
            checks++;
            if (v_ch_q[0] != 0 || v_ch_q[1] != 1 % NUM_CH) begin
                errors++; $display("FAIL midrst_ch: got %0d,%0d want 0,%0d", v_ch_q[0], v_ch_q[1], 1 % NUM_CH);
            end
        end
    endtask

    task automatic test_zero_check();
        int n;
        clear_logs();
        @(posedge clk);
        #1 err_inject = 1'b1;
        n = v_ch_q.size();
        wait_valids(n + 3, 5 * PERIOD, "zchk");
        for (int k = n + 1; k < n + 3 && k < v_ch_q.size(); k++) begin
            checks++;
            if (v_err_q[k] != int'(ERR_EXP)) begin
                errors++; $display("FAIL zchk_err[%0d]: got %0d want %0d", k - n, v_err_q[k], ERR_EXP);
            end
            checks++;
            if (v_data_q[k] != int'(chan_val[v_ch_q[k]])) begin
                errors++; $display("FAIL zchk_data[%0d]: got %h want %h", k - n, v_data_q[k], chan_val[v_ch_q[k]]);
            end
        end
        err_inject = 1'b0;
        n = v_ch_q.size();
        wait_valids(n + 2, 4 * PERIOD, "zclr");
        if (v_ch_q.size() >= n + 2) begin
            checks++;
            if (v_err_q[n+1] != 0) begin
                errors++; $display("FAIL zclr_err: got %0d want 0", v_err_q[n+1]);
            end
        end
        checks++;
        if (err_unqual != 0) begin
            errors++; $display("FAIL zchk_unqualified: frame_err high without sample_valid %0d times, want 0", err_unqual);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) chan_val[i] = 12'hA5C;
        test_reset();
        test_scan(1'b0);
        test_enable_drop();
        test_reset_midframe();
        test_zero_check();
        test_scan(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
